receiver: RTL
=============

Name: receiver

Overview:
- GMII receive engine: the RX-side counterpart of the TX frame-slot sender.
- Accepts frames on the GMII RX interface and strips the preamble/SFD.
- Writes each frame into the RX frame-slot memory in the same raw slot format the sender consumes: magic, frame_len, 64-bit timestamp, 32-bit hash, then frame data as 16-bit words.
- Publishes completed slots by advancing mem_wr_ptr; the downstream PCI-side reader consumes them via mem_rd_ptr.

Parameters:
- MAX_FRAME_LEN, 1518: largest accepted frame in bytes, including FCS.
- MIN_FRAME_LEN, 64: smallest accepted frame in bytes, including FCS.
- RX_MAGIC, 16'h5555: magic word written at slot offset 0 for every committed frame.

Ports:
- gmii_rx_clk  in  1  sole clock, 125 MHz.
- sys_rst  in  1  synchronous, active-high reset.
- global_counter  in  64  free-running timestamp, already in the gmii_rx_clk domain.
- gmii_rxd  in  8  GMII receive data.
- gmii_rx_dv  in  1  GMII data valid.
- gmii_rx_er  in  1  GMII receive error.
- slot_rx_eth_data  out  16  slot write data.
- slot_rx_eth_byte_en  out  2  byte enables; [1] selects bits [15:8].
- slot_rx_eth_addr  out  14  slot word address.
- slot_rx_eth_wr_en  out  1  slot write strobe.
- mem_rd_ptr  in  14  consumer read pointer, in words.
- mem_wr_ptr  out  14  producer write pointer, in words; advanced only on commit.
- rx_drop_count  out  32  saturating count of dropped frames.

Behaviour:
- Reset values: all outputs 0; state RX_IDLE.
- Reset asserted mid-frame: the frame is discarded and mem_wr_ptr returns to 0.
- Slot layout, word offsets from the slot base (base = mem_wr_ptr):
  - 0: magic.
  - 1: frame_len.
  - 2..5: timestamp, [63:48] first.
  - 6..7: hash, [31:16] first.
  - 8 onward: data.
- frame_len = received byte count excluding FCS.
- hash = the 4 received FCS bytes, first byte in [31:24].
- Data packing:
  - Byte 2k goes to [15:8] of word 8+k; byte 2k+1 goes to [7:0].
  - The word is written when its second byte arrives, with byte_en=2'b11.
  - A trailing odd byte is written at end of frame with byte_en=2'b10.
  - FCS bytes are also written into the data area; they are harmless, because the sender re-generates FCS.
- All address arithmetic is modulo 2^14 (wraps).
- Free space = mem_rd_ptr - mem_wr_ptr - 1, modulo 2^14.
- State RX_IDLE:
  - Wait for gmii_rx_dv=1 with gmii_rxd=8'h55 → RX_PREAMBLE.
  - dv=1 with any other byte → RX_DROP.
- State RX_PREAMBLE:
  - 8'h55: stay.
  - 8'hd5 (SFD): latch global_counter as the timestamp and clear the byte count.
    - If free space < MAX_FRAME_LEN+8 → RX_DROP.
    - Otherwise → RX_DATA.
  - Any other byte, or dv falling → RX_IDLE, with no drop count.
- State RX_DATA:
  - Each dv=1 cycle stores one byte, increments the byte count, and shifts the byte into a 32-bit FCS shift register.
  - gmii_rx_er=1 → RX_DROP.
  - Byte count reaching MAX_FRAME_LEN+1 → RX_DROP.
  - dv falls:
    - Flush the odd byte if any.
    - If byte count < MIN_FRAME_LEN → drop: increment the counter, then → RX_IDLE, or RX_DROP if dv is still high.
    - Otherwise → RX_HDR.
- State RX_HDR:
  - 8 consecutive cycles write offsets 0..7, with wr_en=1 and byte_en=2'b11.
  - Then → RX_COMMIT.
  - Any dv activity during RX_HDR is ignored; that frame is lost with no count.
- State RX_COMMIT:
  - mem_wr_ptr <= mem_wr_ptr + frame_len[13:0] + 14'd8.
  - This is the same stride rule the sender uses when advancing mem_rd_ptr.
  - Then → RX_IDLE.
- State RX_DROP:
  - rx_drop_count increments once on entry and saturates at 32'hFFFFFFFF.
  - mem_wr_ptr is unchanged; data already written is abandoned.
  - Wait for dv=0 → RX_IDLE.
- mem_wr_ptr changes only in RX_COMMIT, so the consumer never sees a partial slot.
- Latency: mem_wr_ptr updates exactly 10 cycles after the first dv=0 cycle: 1 flush/decision + 8 header + 1 commit.
- Minimum IFG of 12 cycles is therefore sufficient to catch the next preamble.

Test Plan:
- Single frame of 64 bytes (60 data + FCS) with mem_wr_ptr=0, mem_rd_ptr=0, and global_counter=0x1234 at SFD → required response:
  - Words 8..39 hold the data, FCS included.
  - Word 0 = 16'h5555, word 1 = 16'd60.
  - Words 2..5 = 0,0,0,16'h1234; words 6..7 = the FCS bytes.
  - mem_wr_ptr = 68, 10 cycles after dv falls.
- Odd-length frame of 65 bytes → required response:
  - Last data word written with byte_en=2'b10.
  - frame_len = 61; mem_wr_ptr += 69.
- Frame with gmii_rx_er pulsed at byte 20 → mem_wr_ptr unchanged and rx_drop_count=1.
  - A following good frame is then received normally.
- Insufficient space (mem_rd_ptr = mem_wr_ptr + 100) with a 64-byte frame → frame dropped, rx_drop_count +1, mem_wr_ptr unchanged.
- Wrap-around with mem_wr_ptr=14'h3FF0, mem_rd_ptr=14'h3FF0 → required response:
  - Data addresses wrap through 0.
  - mem_wr_ptr = (14'h3FF0 + 60 + 8) mod 2^14 = 14'h0034.
- Runt (40 bytes) and oversize (1600 bytes) frames → both dropped and counted (rx_drop_count=2); sys_rst asserted mid-frame → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/receiver_if.sv
// Slot-memory write port of the GMII receive engine.
// The receiver drives it as master; the frame-slot RAM is the slave.
interface receiver_if;
    logic [15:0] slot_rx_eth_data;
    logic [1:0]  slot_rx_eth_byte_en;
    logic [13:0] slot_rx_eth_addr;
    logic        slot_rx_eth_wr_en;

    modport master (
        output slot_rx_eth_data,
        output slot_rx_eth_byte_en,
        output slot_rx_eth_addr,
        output slot_rx_eth_wr_en
    );

    modport slave (
        input slot_rx_eth_data,
        input slot_rx_eth_byte_en,
        input slot_rx_eth_addr,
        input slot_rx_eth_wr_en
    );
endinterface

// File: rtl/receiver.sv
// GMII receive engine: strips preamble/SFD and writes each frame into the RX slot memory
// as magic, length, timestamp, hash, then data words; a slot is published only on commit.
module receiver #(
    parameter int unsigned MAX_FRAME_LEN = 1518,
    parameter int unsigned MIN_FRAME_LEN = 64,
    parameter logic [15:0] RX_MAGIC      = 16'h5555
) (
    input  logic        gmii_rx_clk,
    input  logic        sys_rst,
    input  logic [63:0] global_counter,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    receiver_if.master  slot,
    input  logic [13:0] mem_rd_ptr,
    output logic [13:0] mem_wr_ptr,
    output logic [31:0] rx_drop_count
);

    localparam logic [13:0] SpaceNeed = 14'(MAX_FRAME_LEN + 8);
    localparam logic [10:0] CntOver   = 11'(MAX_FRAME_LEN + 1);
    localparam logic [10:0] CntMin    = 11'(MIN_FRAME_LEN);

    typedef enum logic [2:0] {
        RxIdle, RxPreamble, RxData, RxHdr, RxCommit, RxDrop
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [63:0] ts_q, ts_d;
    logic [31:0] fcs_q, fcs_d;
    logic [7:0]  hi_q, hi_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic [13:0] wr_ptr_q, wr_ptr_d;
    logic [31:0] drop_q, drop_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  wbe_q, wbe_d;
    logic [13:0] waddr_q, waddr_d;
    logic        wen_q, wen_d;

    logic        count_drop;
    logic [13:0] free_space;
    logic [13:0] data_addr;
    logic [10:0] cnt_inc;
    logic [10:0] frame_len;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        ts_d       = ts_q;
        fcs_d      = fcs_q;
        hi_d       = hi_q;
        hdr_idx_d  = hdr_idx_q;
        wr_ptr_d   = wr_ptr_q;
        wen_d      = 1'b0;
        wdata_d    = wdata_q;
        wbe_d      = wbe_q;
        waddr_d    = waddr_q;
        count_drop = 1'b0;

        free_space = mem_rd_ptr - wr_ptr_q - 14'd1;
        cnt_inc    = byte_cnt_q + 11'd1;
        data_addr  = wr_ptr_q + 14'd8 + 14'(byte_cnt_q >> 1);
        // Byte count includes the 4 FCS bytes.
        frame_len  = byte_cnt_q - 11'd4;

        unique case (state_q)
            RxIdle: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == 8'h55) begin
                        state_d = RxPreamble;
                    end else begin
                        state_d    = RxDrop;
                        count_drop = 1'b1;
                    end
                end
            end
            RxPreamble: begin
                if (gmii_rx_dv && gmii_rxd == 8'h55) begin
                    state_d = RxPreamble;
                end else if (gmii_rx_dv && gmii_rxd == 8'hd5) begin
                    ts_d       = global_counter;
                    byte_cnt_d = '0;
                    if (free_space < SpaceNeed) begin
                        state_d    = RxDrop;
                        count_drop = 1'b1;
                    end else begin
                        state_d = RxData;
                    end
                end else begin
                    state_d = RxIdle;
                end
            end
            RxData: begin
                if (gmii_rx_dv) begin
                    byte_cnt_d = cnt_inc;
                    fcs_d      = {fcs_q[23:0], gmii_rxd};
                    if (!byte_cnt_q[0]) begin
                        hi_d = gmii_rxd;
                    end else begin
                        wen_d   = 1'b1;
                        wdata_d = {hi_q, gmii_rxd};
                        wbe_d   = 2'b11;
                        waddr_d = data_addr;
                    end
                    if (gmii_rx_er || cnt_inc == CntOver) begin
                        state_d    = RxDrop;
                        count_drop = 1'b1;
                    end
                end else begin
                    if (byte_cnt_q[0]) begin
                        wen_d   = 1'b1;
                        wdata_d = {hi_q, 8'h00};
                        wbe_d   = 2'b10;
                        waddr_d = data_addr;
                    end
                    if (byte_cnt_q < CntMin) begin
                        count_drop = 1'b1;
                        state_d    = RxIdle;
                    end else begin
                        state_d   = RxHdr;
                        hdr_idx_d = '0;
                    end
                end
            end
            RxHdr: begin
                wen_d   = 1'b1;
                wbe_d   = 2'b11;
                waddr_d = wr_ptr_q + 14'(hdr_idx_q);
                unique case (hdr_idx_q)
                    3'd0: wdata_d = RX_MAGIC;
                    3'd1: wdata_d = 16'(frame_len);
                    3'd2: wdata_d = ts_q[63:48];
                    3'd3: wdata_d = ts_q[47:32];
                    3'd4: wdata_d = ts_q[31:16];
                    3'd5: wdata_d = ts_q[15:0];
                    3'd6: wdata_d = fcs_q[31:16];
                    3'd7: wdata_d = fcs_q[15:0];
                endcase
                hdr_idx_d = hdr_idx_q + 3'd1;
                if (hdr_idx_q == 3'd7) begin
                    state_d = RxCommit;
                end
            end
            RxCommit: begin
                // Same stride the sender uses when it advances the read pointer.
                wr_ptr_d = wr_ptr_q + 14'(frame_len) + 14'd8;
                state_d  = RxIdle;
            end
            RxDrop: begin
                if (!gmii_rx_dv) begin
                    state_d = RxIdle;
                end
            end
            default: state_d = RxIdle;
        endcase

        drop_d = (count_drop && drop_q != 32'hFFFF_FFFF) ? drop_q + 32'd1 : drop_q;
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (sys_rst) begin
            state_q    <= RxIdle;
            byte_cnt_q <= '0;
            ts_q       <= '0;
            fcs_q      <= '0;
            hi_q       <= '0;
            hdr_idx_q  <= '0;
            wr_ptr_q   <= '0;
            drop_q     <= '0;
            wdata_q    <= '0;
            wbe_q      <= '0;
            waddr_q    <= '0;
            wen_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            ts_q       <= ts_d;
            fcs_q      <= fcs_d;
            hi_q       <= hi_d;
            hdr_idx_q  <= hdr_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            drop_q     <= drop_d;
            wdata_q    <= wdata_d;
            wbe_q      <= wbe_d;
            waddr_q    <= waddr_d;
            wen_q      <= wen_d;
        end
    end

    assign slot.slot_rx_eth_data    = wdata_q;
    assign slot.slot_rx_eth_byte_en = wbe_q;
    assign slot.slot_rx_eth_addr    = waddr_q;
    assign slot.slot_rx_eth_wr_en   = wen_q;
    assign mem_wr_ptr               = wr_ptr_q;
    assign rx_drop_count            = drop_q;

endmodule
